// File: rtl/vbs_me_pkg.sv
// Shared types and width helpers for the VBS motion-estimation datapath.
// PIX_WIDTH_DEF is the pixel width shared with the PE array.
package vbs_me_pkg;

   localparam int PIX_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCUM   = 2'd1,
      ST_COMPARE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   function automatic int calc_sad_w(input int pix_w, input int pe_x, input int blk_rows);
      return pix_w + $clog2(pe_x * blk_rows);
   endfunction

   function automatic int calc_mv_w(input int search_n);
      return $clog2(search_n) + 1;
   endfunction

   // Counter width that never collapses to zero bits for a range of one.
   function automatic int calc_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vbs_me_sad_min_if.sv
// Handshake bundle between the macroblock controller (master) and the
// SAD-minimum stage (slave): start/busy, AD beat stream and result channel.
interface vbs_me_sad_min_if
   import vbs_me_pkg::*;
#(
   parameter int PIX_WIDTH = PIX_WIDTH_DEF,
   parameter int PE_X      = 2,
   parameter int BLK_ROWS  = 4,
   parameter int SEARCH_W  = 8,
   parameter int SEARCH_H  = 8
) ();

   localparam int SAD_W = calc_sad_w(PIX_WIDTH, PE_X, BLK_ROWS);
   localparam int MVX_W = calc_mv_w(SEARCH_W);
   localparam int MVY_W = calc_mv_w(SEARCH_H);

   logic                           start;
   logic                           busy;
   logic                           ad_valid;
   logic                           ad_ready;
   logic [PE_X-1:0][PIX_WIDTH-1:0] ad_in;
   logic                           res_valid;
   logic                           res_ready;
   logic [SAD_W-1:0]               best_sad;
   logic [MVX_W-1:0]               best_mvx;
   logic [MVY_W-1:0]               best_mvy;

   modport master (
      output start, ad_valid, ad_in, res_ready,
      input  busy, ad_ready, res_valid, best_sad, best_mvx, best_mvy
   );

   modport slave (
      input  start, ad_valid, ad_in, res_ready,
      output busy, ad_ready, res_valid, best_sad, best_mvx, best_mvy
   );

endinterface

// File: rtl/vbs_me_ad_sum.sv
// Combinational sum of the PE_X absolute-difference lanes of one beat.
// Output is wide enough that the sum can never overflow.
module vbs_me_ad_sum
   import vbs_me_pkg::*;
#(
   parameter  int PIX_WIDTH = PIX_WIDTH_DEF,
   parameter  int PE_X      = 2,
   localparam int SUM_W     = PIX_WIDTH + $clog2(PE_X)
) (
   input  logic [PE_X-1:0][PIX_WIDTH-1:0] i_ad,
   output logic [SUM_W-1:0]               o_sum
);

   // Lane adder
   always_comb begin
      o_sum = {SUM_W{1'b0}};
      for (int i = 0; i < PE_X; i++) begin
         o_sum = o_sum + SUM_W'(i_ad[i]);
      end
   end

endmodule

// File: rtl/vbs_me_sad_min.sv
// SAD accumulate / minimum-search stage of the VBS motion-estimation array.
// Optional macro VBS_ME_SAD_MIN_EARLY_TERM_EN: stop the scan at the first zero SAD.
module vbs_me_sad_min
   import vbs_me_pkg::*;
#(
   parameter int PIX_WIDTH = PIX_WIDTH_DEF,
   parameter int PE_X      = 2,
   parameter int BLK_ROWS  = 4,
   parameter int SEARCH_W  = 8,
   parameter int SEARCH_H  = 8
) (
   input  logic              clk,
   input  logic              rst,
   vbs_me_sad_min_if.slave   bus
);

   localparam int SAD_W = calc_sad_w(PIX_WIDTH, PE_X, BLK_ROWS);
   localparam int MVX_W = calc_mv_w(SEARCH_W);
   localparam int MVY_W = calc_mv_w(SEARCH_H);
   localparam int SUM_W = PIX_WIDTH + $clog2(PE_X);
   localparam int ROW_W = calc_cnt_w(BLK_ROWS);
   localparam int PX_W  = calc_cnt_w(SEARCH_W);
   localparam int PY_W  = calc_cnt_w(SEARCH_H);

   state_e           r_state;
   state_e           w_next;
   logic             r_ad_ready;
   logic             r_busy;
   logic             r_res_valid;
   logic [ROW_W-1:0] r_row_cnt;
   logic [PX_W-1:0]  r_pos_x;
   logic [PY_W-1:0]  r_pos_y;
   logic [SAD_W-1:0] r_acc;
   logic [SAD_W-1:0] r_min_sad;
   logic [MVX_W-1:0] r_mv_x;
   logic [MVY_W-1:0] r_mv_y;
   logic             r_found;

   logic [SUM_W-1:0] w_lane_sum;
   logic             w_beat;
   logic             w_last_row;
   logic             w_last_pos;
   logic             w_better;
   logic             w_early;

   vbs_me_ad_sum #(
      .PIX_WIDTH (PIX_WIDTH),
      .PE_X      (PE_X)
   ) u_ad_sum (
      .i_ad  (bus.ad_in),
      .o_sum (w_lane_sum)
   );

   // ad_ready is high exactly while in ACCUM, so this is the accept strobe
   assign w_beat     = bus.ad_valid && r_ad_ready;
   assign w_last_row = (r_row_cnt == ROW_W'(BLK_ROWS - 1));
   assign w_last_pos = (r_pos_x == PX_W'(SEARCH_W - 1)) && (r_pos_y == PY_W'(SEARCH_H - 1));
   assign w_better   = !r_found || (r_acc < r_min_sad);

`ifdef VBS_ME_SAD_MIN_EARLY_TERM_EN
   assign w_early = (r_acc == {SAD_W{1'b0}});
`else
   assign w_early = 1'b0;
`endif

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) w_next = ST_ACCUM;
            else           w_next = ST_IDLE;
         end
         ST_ACCUM: begin
            if (w_beat && w_last_row) w_next = ST_COMPARE;
            else                      w_next = ST_ACCUM;
         end
         ST_COMPARE: begin
            if (w_last_pos || w_early) w_next = ST_DONE;
            else                       w_next = ST_ACCUM;
         end
         ST_DONE: begin
            if (bus.res_ready) w_next = ST_IDLE;
            else               w_next = ST_DONE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State register and handshake outputs, registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ad_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_res_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_ad_ready  <= (w_next == ST_ACCUM);
         r_busy      <= (w_next != ST_IDLE);
         r_res_valid <= (w_next == ST_DONE);
      end
   end

   // Accumulator, raster position and running minimum
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row_cnt <= {ROW_W{1'b0}};
         r_pos_x   <= {PX_W{1'b0}};
         r_pos_y   <= {PY_W{1'b0}};
         r_acc     <= {SAD_W{1'b0}};
         r_min_sad <= {SAD_W{1'b0}};
         r_mv_x    <= {MVX_W{1'b0}};
         r_mv_y    <= {MVY_W{1'b0}};
         r_found   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_row_cnt <= {ROW_W{1'b0}};
                  r_pos_x   <= {PX_W{1'b0}};
                  r_pos_y   <= {PY_W{1'b0}};
                  r_acc     <= {SAD_W{1'b0}};
                  r_min_sad <= {SAD_W{1'b1}};
                  r_found   <= 1'b0;
               end
            end
            ST_ACCUM: begin
               if (w_beat) begin
                  r_acc     <= r_acc + SAD_W'(w_lane_sum);
                  r_row_cnt <= r_row_cnt + ROW_W'(1);
               end
            end
            ST_COMPARE: begin
               // Strict compare: on a tie the earlier raster position stays
               if (w_better) begin
                  r_min_sad <= r_acc;
                  r_mv_x    <= MVX_W'(r_pos_x) - MVX_W'(SEARCH_W / 2);
                  r_mv_y    <= MVY_W'(r_pos_y) - MVY_W'(SEARCH_H / 2);
                  r_found   <= 1'b1;
               end
               r_acc     <= {SAD_W{1'b0}};
               r_row_cnt <= {ROW_W{1'b0}};
               if (r_pos_x == PX_W'(SEARCH_W - 1)) begin
                  r_pos_x <= {PX_W{1'b0}};
                  r_pos_y <= r_pos_y + PY_W'(1);
               end else begin
                  r_pos_x <= r_pos_x + PX_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ad_ready  = r_ad_ready;
   assign bus.busy      = r_busy;
   assign bus.res_valid = r_res_valid;
   assign bus.best_sad  = r_min_sad;
   assign bus.best_mvx  = r_mv_x;
   assign bus.best_mvy  = r_mv_y;

endmodule
